// File: rtl/puf_ctrl_pkg.sv
// Shared types and widths for the PUF key sequencer.
package puf_ctrl_pkg;

    localparam int unsigned PUF_WIDTH   = 64;
    localparam int unsigned CHAL_WIDTH  = 2;
    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        SAMPLE = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage : puf_ctrl_pkg

// File: rtl/puf_bit_voter.sv
// One PUF bit: synchroniser, vote counter, majority / unanimity decode.
module puf_bit_voter
    import puf_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic clr,
    input  logic sample,
    output logic majority_c,
    output logic unstable_c
);

    localparam int unsigned VOTE_W = $clog2(NUM_SAMPLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [VOTE_W-1:0]      votes_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Shift the asynchronous raw bit through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Count synchronised ones on each sample strobe; clear on a new request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            votes_q <= '0;
        end else if (clr) begin
            votes_q <= '0;
        end else if (sample && synced) begin
            votes_q <= votes_q + VOTE_W'(1);
        end
    end

    assign majority_c = (votes_q > VOTE_W'(NUM_SAMPLES / 2));
    assign unstable_c = (votes_q != '0) && (votes_q != VOTE_W'(NUM_SAMPLES));

endmodule : puf_bit_voter

// File: rtl/puf_key_ctrl.sv
// Sequences one PUF challenge: settle, repeated sampling, majority vote into a key.
module puf_key_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned NUM_SAMPLES   = 5,
    parameter int unsigned SAMPLE_GAP    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CHAL_WIDTH-1:0] challenge,
    output logic                  busy,
    output logic                  key_valid,
    output logic [PUF_WIDTH-1:0]  key,
    output logic [PUF_WIDTH-1:0]  unstable_mask,
    output logic                  puf_enable,
    output logic [CHAL_WIDTH-1:0] puf_control,
    input  logic [PUF_WIDTH-1:0]  puf_response
);

    // One timer serves both the settle and the gap phases.
    localparam int unsigned TMR_MAX  = (SETTLE_CYCLES > SAMPLE_GAP) ? SETTLE_CYCLES : SAMPLE_GAP;
    localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);
    localparam int unsigned SMP_W    = $clog2(NUM_SAMPLES + 1);
    localparam int unsigned GAP_LAST = (SAMPLE_GAP > 0) ? (SAMPLE_GAP - 1) : 0;

    state_t                 state_q, state_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic [SMP_W-1:0]       smp_q, smp_d;
    logic                   busy_d, key_valid_d, puf_enable_d;
    logic [PUF_WIDTH-1:0]   key_d, unstable_mask_d;
    logic [CHAL_WIDTH-1:0]  puf_control_d;
    logic                   vote_clr_c, vote_smp_c;
    logic [PUF_WIDTH-1:0]   majority_c, unstable_c;

    // Per-bit synchroniser and voter.
    for (genvar i = 0; i < int'(PUF_WIDTH); i++) begin : g_bit
        puf_bit_voter #(
            .NUM_SAMPLES (NUM_SAMPLES)
        ) u_voter (
            .clk        (clk),
            .rst_n      (rst_n),
            .raw        (puf_response[i]),
            .clr        (vote_clr_c),
            .sample     (vote_smp_c),
            .majority_c (majority_c[i]),
            .unstable_c (unstable_c[i])
        );
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tmr_q         <= '0;
            smp_q         <= '0;
            busy          <= 1'b0;
            key_valid     <= 1'b0;
            key           <= '0;
            unstable_mask <= '0;
            puf_enable    <= 1'b0;
            puf_control   <= '0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            smp_q         <= smp_d;
            busy          <= busy_d;
            key_valid     <= key_valid_d;
            key           <= key_d;
            unstable_mask <= unstable_mask_d;
            puf_enable    <= puf_enable_d;
            puf_control   <= puf_control_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d         = state_q;
        tmr_d           = tmr_q;
        smp_d           = smp_q;
        busy_d          = busy;
        key_valid_d     = key_valid;
        key_d           = key;
        unstable_mask_d = unstable_mask;
        puf_enable_d    = puf_enable;
        puf_control_d   = puf_control;
        vote_clr_c      = 1'b0;
        vote_smp_c      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (abort) begin
                    key_valid_d     = 1'b0;
                    key_d           = '0;
                    unstable_mask_d = '0;
                end else if (start) begin
                    puf_control_d   = challenge;
                    puf_enable_d    = 1'b1;
                    busy_d          = 1'b1;
                    key_valid_d     = 1'b0;
                    key_d           = '0;
                    unstable_mask_d = '0;
                    vote_clr_c      = 1'b1;
                    tmr_d           = '0;
                    smp_d           = '0;
                    state_d         = SETTLE;
                end
            end
            SETTLE: begin
                if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) begin
                    tmr_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            SAMPLE: begin
                vote_smp_c = 1'b1;
                smp_d      = smp_q + SMP_W'(1);
                tmr_d      = '0;
                if (SAMPLE_GAP != 0) begin
                    state_d = GAP;
                end else if (smp_q == SMP_W'(NUM_SAMPLES - 1)) begin
                    state_d = DONE;
                end
            end
            GAP: begin
                if (tmr_q == TMR_W'(GAP_LAST)) begin
                    tmr_d   = '0;
                    state_d = (smp_q == SMP_W'(NUM_SAMPLES)) ? DONE : SAMPLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            DONE: begin
                key_d           = majority_c;
                unstable_mask_d = unstable_c;
                key_valid_d     = 1'b1;
                puf_enable_d    = 1'b0;
                busy_d          = 1'b0;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Cancel an in-flight request; nothing partial is exposed.
        if ((state_q != IDLE) && abort) begin
            state_d         = IDLE;
            puf_enable_d    = 1'b0;
            busy_d          = 1'b0;
            key_valid_d     = 1'b0;
            key_d           = '0;
            unstable_mask_d = '0;
            vote_smp_c      = 1'b0;
        end
    end

endmodule : puf_key_ctrl

// File: tb/tb_puf_key_ctrl.sv
// Scoreboard bench for puf_key_ctrl: two configurations, randomized sample patterns.
module tb_puf_key_ctrl;

    localparam int SETTLE = 16;

    typedef struct {
        logic [63:0] key;
        logic [63:0] mask;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst_s   [2];
    logic        start_s [2];
    logic        abort_s [2];
    logic [1:0]  chal_s  [2];
    logic [63:0] resp_s  [2];
    logic        busy_o  [2];
    logic        kv_o    [2];
    logic [63:0] key_o   [2];
    logic [63:0] mask_o  [2];
    logic        en_o    [2];
    logic [1:0]  ctrl_o  [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic kv_prev [2];
    logic [63:0] pat [16];

    puf_key_ctrl #(.SETTLE_CYCLES(16), .NUM_SAMPLES(5), .SAMPLE_GAP(3)) u_dut0 (
        .clk(clk), .rst_n(rst_s[0]), .start(start_s[0]), .abort(abort_s[0]),
        .challenge(chal_s[0]), .busy(busy_o[0]), .key_valid(kv_o[0]), .key(key_o[0]),
        .unstable_mask(mask_o[0]), .puf_enable(en_o[0]), .puf_control(ctrl_o[0]),
        .puf_response(resp_s[0]));

    puf_key_ctrl #(.SETTLE_CYCLES(16), .NUM_SAMPLES(3), .SAMPLE_GAP(0)) u_dut1 (
        .clk(clk), .rst_n(rst_s[1]), .start(start_s[1]), .abort(abort_s[1]),
        .challenge(chal_s[1]), .busy(busy_o[1]), .key_valid(kv_o[1]), .key(key_o[1]),
        .unstable_mask(mask_o[1]), .puf_enable(en_o[1]), .puf_control(ctrl_o[1]),
        .puf_response(resp_s[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ns_of(input int d);
        return (d == 0) ? 5 : 3;
    endfunction

    function automatic int gap_of(input int d);
        return (d == 0) ? 3 : 0;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Reference: count ones per bit over the sample patterns, then vote.
    function automatic void model(input int ns, output logic [63:0] k, output logic [63:0] m);
        k = '0;
        m = '0;
        for (int b = 0; b < 64; b++) begin
            int ones = 0;
            for (int s = 0; s < ns; s++) ones += int'(pat[s][b]);
            k[b] = (2 * ones > ns);
            m[b] = (ones != 0) && (ones != ns);
        end
    endfunction

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t actual=%h required=%h", nm, d, $time, act, req);
        end
    endtask

    // Monitor: on each key_valid rise, pop the expected result and compare.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (kv_o[d] === 1'b1 && kv_prev[d] !== 1'b1) begin
                if (qsize(d) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_key_valid dut%0d t=%0t actual=1 required=0", d, $time);
                end else begin
                    exp_t e;
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk("key", d, key_o[d], e.key);
                    chk("unstable_mask", d, mask_o[d], e.mask);
                    chk("latency", d, 64'(cyc - e.acc), 64'(e.lat));
                end
            end
            kv_prev[d] = kv_o[d];
        end
    end

    // mode: 0 normal, 1 abort at cycle 'at', 2 start re-pulse at 'at', 3 reset at 'at'.
    task automatic run_req(input int d, input logic [1:0] ch, input int mode, input int at);
        int ns  = ns_of(d);
        int g   = gap_of(d);
        int tot = 1 + SETTLE + ns * (g + 1);
        int acc;
        logic [63:0] ek, em;
        exp_t e;
        model(ns, ek, em);

        @(negedge clk);
        start_s[d] = 1'b1;
        chal_s[d]  = ch;
        resp_s[d]  = rnd64();
        @(posedge clk);
        #1;
        acc        = cyc;
        start_s[d] = 1'b0;
        chal_s[d]  = 2'($urandom);
        if (mode == 0 || mode == 2) begin
            e.key = ek; e.mask = em; e.acc = acc; e.lat = tot;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        chk("accept_control", d, 64'(ctrl_o[d]), 64'(ch));
        chk("accept_enable", d, 64'(en_o[d]), 64'd1);
        chk("accept_busy", d, 64'(busy_o[d]), 64'd1);
        chk("accept_key_valid", d, 64'(kv_o[d]), 64'd0);

        // Iteration o runs on the negedge after edge acc+o; sample k sees the
        // value present two edges before its counting edge.
        for (int o = 0; o <= tot + 2; o++) begin
            int rel;
            @(negedge clk);
            rel = o - (SETTLE - 2);
            if (rel >= 0 && (rel % (g + 1)) == 0 && (rel / (g + 1)) < ns)
                resp_s[d] = pat[rel / (g + 1)];
            else
                resp_s[d] = rnd64();
            if (mode == 1 && o == at - 1) begin
                abort_s[d] = 1'b1;
                @(posedge clk);
                #1;
                abort_s[d] = 1'b0;
                chk("abort_enable", d, 64'(en_o[d]), 64'd0);
                chk("abort_busy", d, 64'(busy_o[d]), 64'd0);
                chk("abort_key_valid", d, 64'(kv_o[d]), 64'd0);
                break;
            end
            if (mode == 2 && o == at - 1) begin
                start_s[d] = 1'b1;
                chal_s[d]  = 2'b01;
                @(posedge clk);
                #1;
                start_s[d] = 1'b0;
                chk("repulse_control", d, 64'(ctrl_o[d]), 64'(ch));
                chk("repulse_busy", d, 64'(busy_o[d]), 64'd1);
            end
            if (mode == 3 && o == at - 1) begin
                #1;
                rst_s[d] = 1'b0;
                #1;
                chk("rst_busy", d, 64'(busy_o[d]), 64'd0);
                chk("rst_enable", d, 64'(en_o[d]), 64'd0);
                chk("rst_control", d, 64'(ctrl_o[d]), 64'd0);
                chk("rst_key_valid", d, 64'(kv_o[d]), 64'd0);
                chk("rst_key", d, key_o[d], 64'd0);
                chk("rst_mask", d, mask_o[d], 64'd0);
                @(negedge clk);
                rst_s[d] = 1'b1;
                break;
            end
        end

        if (mode == 1 || mode == 3) begin
            repeat (45) @(negedge clk);
            chk("idle_key_valid", d, 64'(kv_o[d]), 64'd0);
            chk("idle_busy", d, 64'(busy_o[d]), 64'd0);
        end else begin
            for (int w = 0; w < 100 && qsize(d) != 0; w++) @(negedge clk);
            if (qsize(d) != 0) begin
                checks++;
                errors++;
                $display("FAIL completion_timeout dut%0d actual=pending required=done", d);
                if (d == 0) q0.delete();
                else        q1.delete();
            end
            repeat (4) @(negedge clk);
            chk("hold_key_valid", d, 64'(kv_o[d]), 64'd1);
            chk("hold_key", d, key_o[d], ek);
            chk("hold_mask", d, mask_o[d], em);
            chk("done_busy", d, 64'(busy_o[d]), 64'd0);
            chk("done_enable", d, 64'(en_o[d]), 64'd0);
            chk("done_control", d, 64'(ctrl_o[d]), 64'(ch));
        end
    endtask

    task automatic fill_const(input logic [63:0] v);
        for (int s = 0; s < 16; s++) pat[s] = v;
    endtask

    task automatic fill_random();
        logic [63:0] base = rnd64();
        for (int s = 0; s < 16; s++) pat[s] = base ^ (rnd64() & rnd64() & rnd64());
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_s[d] = 1'b0; start_s[d] = 1'b0; abort_s[d] = 1'b0;
            chal_s[d] = 2'b00; resp_s[d] = '0; kv_prev[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_busy", d, 64'(busy_o[d]), 64'd0);
            chk("reset_key_valid", d, 64'(kv_o[d]), 64'd0);
            chk("reset_key", d, key_o[d], 64'd0);
            chk("reset_mask", d, mask_o[d], 64'd0);
            chk("reset_enable", d, 64'(en_o[d]), 64'd0);
            chk("reset_control", d, 64'(ctrl_o[d]), 64'd0);
        end
        rst_s[0] = 1'b1;
        rst_s[1] = 1'b1;
        repeat (2) @(negedge clk);

        // Constant response.
        fill_const(64'hDEADBEEF_01234567);
        run_req(0, 2'b10, 0, 0);

        // Noisy bit0 (samples 1,3,5) and bit63 (samples 2,4).
        fill_const(64'h0);
        pat[0][0] = 1'b1; pat[2][0] = 1'b1; pat[4][0] = 1'b1;
        pat[1][63] = 1'b1; pat[3][63] = 1'b1;
        run_req(0, 2'b00, 0, 0);

        // Abort in SETTLE, then a fresh request.
        fill_random();
        run_req(0, 2'b01, 1, 10);
        fill_random();
        run_req(0, 2'b11, 0, 0);

        // Start re-pulse while busy.
        fill_random();
        run_req(0, 2'b11, 2, 20);

        // Abort in IDLE with a valid key clears it.
        @(negedge clk);
        abort_s[0] = 1'b1;
        @(posedge clk);
        #1;
        abort_s[0] = 1'b0;
        chk("idle_abort_key_valid", 0, 64'(kv_o[0]), 64'd0);
        chk("idle_abort_key", 0, key_o[0], 64'd0);
        chk("idle_abort_mask", 0, mask_o[0], 64'd0);

        // Reset mid-request, then a normal request.
        fill_random();
        run_req(0, 2'b10, 3, 25);
        fill_random();
        run_req(0, 2'b01, 0, 0);

        // Start and abort together in IDLE.
        @(negedge clk);
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        chal_s[0]  = 2'b11;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("start_abort_busy", 0, 64'(busy_o[0]), 64'd0);
        chk("start_abort_enable", 0, 64'(en_o[0]), 64'd0);
        chk("start_abort_key_valid", 0, 64'(kv_o[0]), 64'd0);

        // Back-to-back sampling configuration.
        fill_const(64'hDEADBEEF_01234567);
        run_req(1, 2'b10, 0, 0);
        fill_const(64'h0);
        pat[0][0] = 1'b1; pat[2][0] = 1'b1;
        pat[1][63] = 1'b1;
        run_req(1, 2'b01, 0, 0);
        fill_random();
        run_req(1, 2'b11, 1, 18);

        // Randomized requests on both configurations.
        for (int r = 0; r < 6; r++) begin
            for (int d = 0; d < 2; d++) begin
                fill_random();
                run_req(d, 2'($urandom), 0, 0);
            end
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_puf_key_ctrl
